nibble_splitter: RTL and testbench
==================================

Name: nibble_splitter

Overview:
- Byte-to-nibble serializer: the inverse of the nibble-to-byte packing path in the ALU datapath.
- Accepts one 2*NIBBLE_W-bit word over a valid/ready handshake and emits its two halves as two consecutive nibble transfers on a second valid/ready handshake.
- Sits between the ALU result register and the nibble-wide consumers (4-bit display digit and operand feedback path).
- Also keeps a running count of completed words.

Parameters:
- NIBBLE_W, 4: width of each output half; input word is 2*NIBBLE_W.
- MSB_FIRST, 1: 1 = upper half sent first; 0 = lower half sent first.
- CNT_W, 8: width of the completed-word counter.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_word  input  2*NIBBLE_W  word to split.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block accepts in_word this cycle.
- out_nibble  output  NIBBLE_W  current half.
- out_valid  output  1  out_nibble is valid.
- out_ready  input  1  consumer accepts out_nibble this cycle.
- out_first  output  1  high with out_valid on the first half of a word.
- out_last  output  1  high with out_valid on the second half of a word.
- word_count  output  CNT_W  number of words fully emitted, modulo 2^CNT_W.

Behaviour:
- Reset is synchronous, active-high; the only clock is clk.
- Reset values: state=IDLE, hold register=0, out_valid=0, out_first=0, out_last=0, word_count=0. out_nibble reads 0.
- in_ready is 1 in IDLE and 0 while reset is high.
- Transfers occur only on a cycle where valid and ready are both 1 at the rising edge.
- States:
  - IDLE: out_valid=0, in_ready=1. An input transfer latches in_word into the hold register, then goes to FIRST.
  - FIRST: out_valid=1, out_first=1, in_ready=0. out_nibble is the upper half if MSB_FIRST=1, else the lower half. On out_ready=1, goes to SECOND; otherwise holds with output stable.
  - SECOND: out_valid=1, out_last=1. out_nibble is the other half. in_ready = out_ready (combinational pass-through).
    - out_ready=1 and in_valid=1: load the new word, go to FIRST, increment word_count.
    - out_ready=1 and in_valid=0: go to IDLE, increment word_count.
    - out_ready=0: hold; in_ready=0.
- Latency: an input accepted at edge N presents its first half at cycle N+1. If out_ready stays high, the second half is at N+2.
- Throughput: one word per two cycles with no bubble between words.
- out_nibble, out_first and out_last are decoded from registered state and hold only; they have no combinational path from inputs.
- Stability: while out_valid=1 and out_ready=0, out_nibble, out_first and out_last must not change.
- in_word is sampled only on an accepted input transfer. Changes at other times are ignored.
- in_valid may drop without a transfer; nothing is buffered.
- word_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-word, in FIRST or SECOND: the held word is discarded, no partial output appears, and word_count is cleared. The next cycle is IDLE.
- Simultaneous reset and in_valid: reset wins; the word is not accepted.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package (alu_pkg): NIBBLE_W default constant and the state encoding (IDLE=2'd0, FIRST=2'd1, SECOND=2'd2). These are reused by the concatenating side and the display path.
- No sub-module required. Implement the half-select mux as a function.
- Optional: a reusable counter module, up_counter, for word_count, if one already exists in the library.

Test Plan:
- Reset, then a single word: in_word=8'hA5, in_valid for 1 cycle, out_ready=1 → out_nibble 4'hA with out_first, then 4'h5 with out_last on consecutive cycles. word_count=1, back to IDLE.
- MSB_FIRST=0 with in_word=8'h3C → 4'hC, then 4'h3.
- Back-to-back stream 8'h12, 8'h34, 8'h56, in_valid and out_ready held high → nibbles 1,2,3,4,5,6 on six consecutive cycles with no gaps. in_ready is high only in the IDLE/SECOND accept cycles. word_count=3.
- Backpressure: in_word=8'h9E, out_ready low for 3 cycles in FIRST, then 2 cycles in SECOND → 4'h9, then 4'hE held stable. in_ready=0 throughout. Each nibble transfers exactly once.
- Reset while in SECOND with word 8'hF0 → next cycle out_valid=0, word_count=0. No 4'h0 nibble is emitted. A new word 8'h77 afterwards splits correctly.
- Wrap: CNT_W=2, send 5 words → word_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/nibble_splitter_pkg.sv
// Shared constants for the nibble datapath: default nibble width and the
// splitter state encoding reused by the packing side and the display path.
package nibble_splitter_pkg;

    localparam int NIBBLE_W_DEF = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_FIRST  = 2'd1;
    localparam state_t ST_SECOND = 2'd2;

endpackage

// File: rtl/nibble_splitter_if.sv
// Word-in / nibble-out handshake bundle. The master side supplies words and
// consumes nibbles; the slave side is the splitter itself.
interface nibble_splitter_if
    import nibble_splitter_pkg::*;
#(
    parameter int NIBBLE_W = NIBBLE_W_DEF
);

    logic [2*NIBBLE_W-1:0] in_word;
    logic                  in_valid;
    logic                  in_ready;
    logic [NIBBLE_W-1:0]   out_nibble;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_first;
    logic                  out_last;

    modport master (
        output in_word,
        output in_valid,
        input  in_ready,
        input  out_nibble,
        input  out_valid,
        output out_ready,
        input  out_first,
        input  out_last
    );

    modport slave (
        input  in_word,
        input  in_valid,
        output in_ready,
        output out_nibble,
        output out_valid,
        input  out_ready,
        output out_first,
        output out_last
    );

endinterface

// File: rtl/nibble_splitter_counter.sv
// Wrapping up-counter with synchronous active-high clear; counts completed
// words and rolls over silently at 2^WIDTH.
module nibble_splitter_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/nibble_splitter.sv
// Byte-to-nibble serializer: takes one 2*NIBBLE_W word and emits its halves
// as two consecutive nibble transfers, counting completed words.
module nibble_splitter
    import nibble_splitter_pkg::*;
#(
    parameter int NIBBLE_W  = NIBBLE_W_DEF,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    nibble_splitter_if.slave bus,
    output logic [CNT_W-1:0] word_count
);

    localparam int WORD_W = 2 * NIBBLE_W;

    function automatic logic [NIBBLE_W-1:0] select_half(
        input logic [WORD_W-1:0] word,
        input logic              upper
    );
        return upper ? word[WORD_W-1:NIBBLE_W] : word[NIBBLE_W-1:0];
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_hold;
    logic [WORD_W-1:0]   w_hold_nxt;
    logic                w_in_ready;
    logic                w_in_fire;
    logic                w_word_done;
    logic [NIBBLE_W-1:0] w_nibble;
    logic                w_out_valid;
    logic                w_out_first;
    logic                w_out_last;

    // SECOND passes out_ready straight through so a new word loads in the
    // same cycle the last half leaves: no bubble between words.
    assign w_in_ready  = !reset &&
                         ((r_state == ST_IDLE) ||
                          ((r_state == ST_SECOND) && bus.out_ready));
    assign w_in_fire   = bus.in_valid && w_in_ready;
    assign w_word_done = (r_state == ST_SECOND) && bus.out_ready;

    always_comb begin
        // NOTE: defaults before the case keep every path assigned, so no latch.
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_in_fire) begin
                    w_hold_nxt  = bus.in_word;
                    w_state_nxt = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (bus.out_ready) begin
                    if (w_in_fire) begin
                        w_hold_nxt  = bus.in_word;
                        w_state_nxt = ST_FIRST;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Outputs decode registered state only, so they stay put under backpressure.
    always_comb begin
        w_out_valid = 1'b0;
        w_out_first = 1'b0;
        w_out_last  = 1'b0;
        w_nibble    = '0;
        case (r_state)
            ST_FIRST: begin
                w_out_valid = 1'b1;
                w_out_first = 1'b1;
                w_nibble    = select_half(r_hold, MSB_FIRST);
            end
            ST_SECOND: begin
                w_out_valid = 1'b1;
                w_out_last  = 1'b1;
                w_nibble    = select_half(r_hold, !MSB_FIRST);
            end
            default: begin
                w_out_valid = 1'b0;
            end
        endcase
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_first  = w_out_first;
    assign bus.out_last   = w_out_last;
    assign bus.out_nibble = w_nibble;

    nibble_splitter_counter #(
        .WIDTH (CNT_W)
    ) u_word_counter (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_word_done),
        .o_count (word_count)
    );

endmodule

// File: tb/tb_nibble_splitter.sv
// Bench for nibble_splitter: three configurations share one stimulus stream and
// are compared against a queue-of-pending-nibbles model of the splitter.
module tb_nibble_splitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_word;

    logic [7:0] cnt_msb;
    logic [7:0] cnt_lsb;
    logic [1:0] cnt_wrap;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nibble_splitter_if #(.NIBBLE_W(4)) bus_msb ();
    nibble_splitter_if #(.NIBBLE_W(4)) bus_lsb ();
    nibble_splitter_if #(.NIBBLE_W(4)) bus_wrap ();

    assign bus_msb.in_word    = in_word;
    assign bus_msb.in_valid   = in_valid;
    assign bus_msb.out_ready  = out_ready;
    assign bus_lsb.in_word    = in_word;
    assign bus_lsb.in_valid   = in_valid;
    assign bus_lsb.out_ready  = out_ready;
    assign bus_wrap.in_word   = in_word;
    assign bus_wrap.in_valid  = in_valid;
    assign bus_wrap.out_ready = out_ready;

    nibble_splitter #(.NIBBLE_W(4), .MSB_FIRST(1'b1), .CNT_W(8)) dut_msb (
        .clk(clk), .reset(reset), .bus(bus_msb), .word_count(cnt_msb));
    nibble_splitter #(.NIBBLE_W(4), .MSB_FIRST(1'b0), .CNT_W(8)) dut_lsb (
        .clk(clk), .reset(reset), .bus(bus_lsb), .word_count(cnt_lsb));
    nibble_splitter #(.NIBBLE_W(4), .MSB_FIRST(1'b1), .CNT_W(2)) dut_wrap (
        .clk(clk), .reset(reset), .bus(bus_wrap), .word_count(cnt_wrap));

    // Model: nibbles still owed to the consumer, in emission order.
    int q[$];
    int m_count;
    bit m_msb;
    int m_mod;
    int sel;

    function automatic logic [15:0] expected_obs();
        int         n;
        logic [3:0] nib;
        logic       rdy;
        logic [7:0] c;
        n   = q.size();
        nib = (n > 0) ? q[0][3:0] : 4'h0;
        rdy = !reset && ((n == 0) || ((n == 1) && out_ready));
        c   = m_count[7:0];
        return {n > 0, n == 2, n == 1, nib, rdy, c};
    endfunction

    function automatic logic [15:0] observe();
        case (sel)
            0: return {bus_msb.out_valid, bus_msb.out_first, bus_msb.out_last,
                       bus_msb.out_nibble, bus_msb.in_ready, cnt_msb};
            1: return {bus_lsb.out_valid, bus_lsb.out_first, bus_lsb.out_last,
                       bus_lsb.out_nibble, bus_lsb.in_ready, cnt_lsb};
            default: return {bus_wrap.out_valid, bus_wrap.out_first, bus_wrap.out_last,
                             bus_wrap.out_nibble, bus_wrap.in_ready, 6'd0, cnt_wrap};
        endcase
    endfunction

    task automatic model_edge();
        bit rdy;
        int w;
        if (reset) begin
            q.delete();
            m_count = 0;
        end else begin
            rdy = (q.size() == 0) || ((q.size() == 1) && out_ready);
            if (out_ready && q.size() > 0) begin
                if (q.size() == 1) m_count = (m_count + 1) % m_mod;
                void'(q.pop_front());
            end
            if (in_valid && rdy) begin
                w = int'(in_word);
                if (m_msb) begin
                    q.push_back(w / 16);
                    q.push_back(w % 16);
                end else begin
                    q.push_back(w % 16);
                    q.push_back(w / 16);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset(input int s);
        sel       = s;
        m_msb     = (s != 1);
        m_mod     = (s == 2) ? 4 : 256;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_word   = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] obs, exp;
        sel = 0; m_msb = 1'b1; m_mod = 256;
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_word = 8'($urandom);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            obs = observe(); exp = expected_obs();
            n_checks++;
            if (obs !== exp) $display("FAIL reset_model cyc %0d: got %h want %h", c, obs, exp);
            else n_pass++;
            n_checks++;
            if ({bus_msb.out_valid, bus_msb.out_first, bus_msb.out_last, bus_msb.out_nibble,
                 bus_msb.in_ready, cnt_msb} !== 16'h0000)
                $display("FAIL reset_state cyc %0d: got %h want 0000", c, observe());
            else n_pass++;
        end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus_msb.in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", bus_msb.in_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_single(input int s, input logic [7:0] word,
                               input logic [3:0] first_nib, input logic [3:0] last_nib);
        logic [15:0] obs, exp;
        logic [6:0]  out_bits;
        apply_reset(s);
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 0); out_ready = 1'b1;
            in_word  = (c == 0) ? word : 8'($urandom);
            #1;
            obs = observe(); exp = expected_obs();
            n_checks++;
            if (obs !== exp) $display("FAIL single_model s%0d cyc %0d: got %h want %h", s, c, obs, exp);
            else n_pass++;
            out_bits = obs[15:9];
            if (c == 1) begin
                n_checks++;
                if (out_bits !== {3'b110, first_nib}) $display("FAIL single_first s%0d: got %h want %h", s, out_bits, {3'b110, first_nib});
                else n_pass++;
            end
            if (c == 2) begin
                n_checks++;
                if (out_bits !== {3'b101, last_nib}) $display("FAIL single_last s%0d: got %h want %h", s, out_bits, {3'b101, last_nib});
                else n_pass++;
            end
            if (c == 3) begin
                n_checks++;
                if ({out_bits[6], obs[7:0]} !== 9'h001) $display("FAIL single_done s%0d: got %h want 001", s, {out_bits[6], obs[7:0]});
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] obs, exp;
        logic [7:0]  words [3];
        words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56;
        apply_reset(0);
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 6); out_ready = 1'b1;
            in_word  = (c < 6) ? words[c/2] : 8'($urandom);
            #1;
            obs = observe(); exp = expected_obs();
            n_checks++;
            if (obs !== exp) $display("FAIL b2b_model cyc %0d: got %h want %h", c, obs, exp);
            else n_pass++;
            if (c >= 1 && c <= 6) begin
                n_checks++;
                if ({bus_msb.out_valid, bus_msb.out_nibble} !== {1'b1, 4'(c)})
                    $display("FAIL b2b_nibble cyc %0d: got %h want %h", c, {bus_msb.out_valid, bus_msb.out_nibble}, {1'b1, 4'(c)});
                else n_pass++;
            end
            n_checks++;
            if (bus_msb.in_ready !== (c % 2 == 0 || c == 7))
                $display("FAIL b2b_in_ready cyc %0d: got %b want %b", c, bus_msb.in_ready, (c % 2 == 0 || c == 7));
            else n_pass++;
            tick();
        end
        n_checks++;
        if (cnt_msb !== 8'd3) $display("FAIL b2b_count: got %0d want 3", cnt_msb);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [15:0] obs, exp;
        apply_reset(0);
        for (int c = 0; c < 9; c++) begin
            in_valid  = (c <= 6);
            in_word   = (c == 0) ? 8'h9E : 8'($urandom);
            out_ready = (c == 0 || c == 4 || c == 7 || c == 8);
            #1;
            obs = observe(); exp = expected_obs();
            n_checks++;
            if (obs !== exp) $display("FAIL bp_model cyc %0d: got %h want %h", c, obs, exp);
            else n_pass++;
            if (c >= 1 && c <= 7) begin
                n_checks++;
                if (obs[15:9] !== ((c <= 4) ? 7'h69 : 7'h5E))
                    $display("FAIL bp_hold cyc %0d: got %h want %h", c, obs[15:9], (c <= 4) ? 7'h69 : 7'h5E);
                else n_pass++;
            end
            if (c >= 1 && c <= 6) begin
                n_checks++;
                if (bus_msb.in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d: got %b want 0", c, bus_msb.in_ready);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if ({bus_msb.out_valid, cnt_msb} !== 9'h001) $display("FAIL bp_count: got %h want 001", {bus_msb.out_valid, cnt_msb});
        else n_pass++;
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] obs, exp;
        apply_reset(0);
        for (int c = 0; c < 10; c++) begin
            reset     = (c == 4);
            out_ready = 1'b1;
            in_valid  = (c == 0 || c == 2 || c == 4 || c == 6);
            in_word   = (c == 0) ? 8'h21 : (c == 2) ? 8'hF0 : (c == 6) ? 8'h77 : 8'($urandom);
            #1;
            obs = observe(); exp = expected_obs();
            n_checks++;
            if (obs !== exp) $display("FAIL midrst_model cyc %0d: got %h want %h", c, obs, exp);
            else n_pass++;
            if (c == 5) begin
                n_checks++;
                if ({bus_msb.out_valid, cnt_msb} !== 9'h000) $display("FAIL midrst_clear: got %h want 000", {bus_msb.out_valid, cnt_msb});
                else n_pass++;
            end
            if (c == 7 || c == 8) begin
                n_checks++;
                if (obs[15:9] !== ((c == 7) ? 7'h67 : 7'h57))
                    $display("FAIL midrst_after cyc %0d: got %h want %h", c, obs[15:9], (c == 7) ? 7'h67 : 7'h57);
                else n_pass++;
            end
            tick();
        end
        reset = 1'b0;
        n_checks++;
        if (cnt_msb !== 8'd1) $display("FAIL midrst_count: got %0d want 1", cnt_msb);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [15:0] obs, exp;
        int          wrap_exp [5];
        wrap_exp = '{1, 2, 3, 0, 1};
        apply_reset(2);
        for (int c = 0; c < 12; c++) begin
            in_valid = (c <= 8); out_ready = 1'b1; in_word = 8'($urandom);
            #1;
            obs = observe(); exp = expected_obs();
            n_checks++;
            if (obs !== exp) $display("FAIL wrap_model cyc %0d: got %h want %h", c, obs, exp);
            else n_pass++;
            if (c >= 3 && c % 2 == 1) begin
                n_checks++;
                if (cnt_wrap !== 2'(wrap_exp[(c-3)/2]))
                    $display("FAIL wrap_count cyc %0d: got %0d want %0d", c, cnt_wrap, wrap_exp[(c-3)/2]);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_random(input int s, input int cycles);
        logic [15:0] obs, exp;
        int          errs;
        errs = 0;
        apply_reset(s);
        for (int c = 0; c < cycles; c++) begin
            reset     = ($urandom_range(63) == 0);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            in_word   = 8'($urandom);
            #1;
            obs = observe(); exp = expected_obs();
            n_checks++;
            if (obs !== exp) begin
                if (errs < 10) $display("FAIL random s%0d cyc %0d: got %h want %h", s, c, obs, exp);
                errs++;
            end else n_pass++;
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_word = 8'h00;
        test_reset();
        test_single(0, 8'hA5, 4'hA, 4'h5);
        test_single(1, 8'h3C, 4'hC, 4'h3);
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_wrap();
        test_random(0, 400);
        test_random(1, 200);
        test_random(2, 200);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
